// File: rtl/img_pkg.sv
// Shared definitions for the pixel capture writer: FSM encoding, default
// frame geometry and a width helper used by the interface and the RTL.
package img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int DEF_IMG_W   = 98;
  localparam int DEF_IMG_H   = 98;
  localparam int DEF_SKIP    = 1;
  localparam int FRAME_CNT_W = 16;

  // Index width for a range of v values, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pixel_capture_writer_if.sv
// Bundle of the capture request, pixel stream, image RAM write port and
// status outputs of pixel_capture_writer.
interface pixel_capture_writer_if
  import img_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int CH     = 2,
  parameter int ADDR_W = 14
);

  localparam int SEL_W = clog2_min1(CH);
  localparam int COL_W = clog2_min1(IMG_W);
  localparam int ROW_W = clog2_min1(IMG_H);

  logic                   start;
  logic [SEL_W-1:0]       ch_sel;
  logic                   in_valid;
  logic [CH*DATA_W-1:0]   in_data;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_din;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   busy;
  logic                   done;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    output start, ch_sel, in_valid, in_data,
    input  mem_we, mem_addr, mem_din, col, row, busy, done, frame_cnt
  );

  modport slave (
    input  start, ch_sel, in_valid, in_data,
    output mem_we, mem_addr, mem_din, col, row, busy, done, frame_cnt
  );

endinterface

// File: rtl/xy_counter.sv
// Raster position counter: column, row and linear address of the next pixel,
// with column wrap into the next row and a flag for the final pixel.
module xy_counter #(
  parameter int IMG_W  = 98,
  parameter int IMG_H  = 98,
  parameter int ADDR_W = 14,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [ADDR_W-1:0] addr_r;
  logic              col_end_s;
  logic              last_s;

  assign col_end_s = (col_r == COL_LAST);
  assign last_s    = col_end_s && (row_r == ROW_LAST);

  // Position advances once per accepted pixel and wraps to the origin after the final one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r  <= {COL_W{1'b0}};
      row_r  <= {ROW_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (clr) begin
      col_r  <= {COL_W{1'b0}};
      row_r  <= {ROW_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (inc) begin
      if (col_end_s) begin
        col_r <= {COL_W{1'b0}};
        row_r <= (row_r == ROW_LAST) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
        row_r <= row_r;
      end
      addr_r <= last_s ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1);
    end else begin
      col_r  <= col_r;
      row_r  <= row_r;
      addr_r <= addr_r;
    end
  end

  assign col  = col_r;
  assign row  = row_r;
  assign addr = addr_r;
  assign last = last_s;

endmodule

// File: rtl/pixel_capture_writer.sv
// Captures one frame from a multi-channel filter pixel stream into an image
// RAM: drops leading samples, then writes the selected channel in raster order.
module pixel_capture_writer
  import img_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int SKIP   = DEF_SKIP,
  parameter int CH     = 2,
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  pixel_capture_writer_if.slave bus
);

  localparam int SEL_W  = clog2_min1(CH);
  localparam int COL_W  = clog2_min1(IMG_W);
  localparam int ROW_W  = clog2_min1(IMG_H);
  localparam int SKIP_W = clog2_min1(SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [SEL_W-1:0]       ch_sel_r;
  logic [SKIP_W-1:0]      skip_cnt_r;
  logic                   cnt_clr_s;
  logic                   cnt_inc_s;
  logic                   cnt_last_s;
  logic                   wr_s;
  logic [COL_W-1:0]       cnt_col_s;
  logic [ROW_W-1:0]       cnt_row_s;
  logic [ADDR_W-1:0]      cnt_addr_s;
  logic [DATA_W-1:0]      pix_s;

  logic                   mem_we_r;
  logic [ADDR_W-1:0]      mem_addr_r;
  logic [DATA_W-1:0]      mem_din_r;
  logic [COL_W-1:0]       col_r;
  logic [ROW_W-1:0]       row_r;
  logic                   busy_r;
  logic                   done_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;

  xy_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_xy (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .inc  (cnt_inc_s),
    .col  (cnt_col_s),
    .row  (cnt_row_s),
    .addr (cnt_addr_s),
    .last (cnt_last_s)
  );

  // Channel select uses the value latched at start so mid-frame changes have no effect.
  always_comb begin
    pix_s = {DATA_W{1'b0}};
    for (int c = 0; c < CH; c++) begin
      pix_s = (ch_sel_r == SEL_W'(c)) ? bus.in_data[c*DATA_W +: DATA_W] : pix_s;
    end
  end

  // Frame sequencing: next state and counter controls.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    wr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (bus.in_valid && (skip_cnt_r == SKIP_LAST)) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_SKIP;
        end
      end
      ST_CAPTURE: begin
        if (bus.in_valid) begin
          wr_s        = 1'b1;
          cnt_inc_s   = 1'b1;
          state_nxt_s = cnt_last_s ? ST_DONE : ST_CAPTURE;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, channel latch and leading-sample counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ch_sel_r   <= {SEL_W{1'b0}};
      skip_cnt_r <= {SKIP_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (cnt_clr_s) begin
        ch_sel_r   <= bus.ch_sel;
        skip_cnt_r <= {SKIP_W{1'b0}};
      end else if ((state_r == ST_SKIP) && bus.in_valid) begin
        ch_sel_r   <= ch_sel_r;
        skip_cnt_r <= skip_cnt_r + SKIP_W'(1);
      end else begin
        ch_sel_r   <= ch_sel_r;
        skip_cnt_r <= skip_cnt_r;
      end
    end
  end

  // Registered write port and status; busy/done track the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_din_r   <= {DATA_W{1'b0}};
      col_r       <= {COL_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      frame_cnt_r <= {FRAME_CNT_W{1'b0}};
    end else begin
      mem_we_r <= wr_s;
      if (wr_s) begin
        mem_addr_r <= cnt_addr_s;
        mem_din_r  <= pix_s;
        col_r      <= cnt_col_s;
        row_r      <= cnt_row_s;
      end else begin
        mem_addr_r <= mem_addr_r;
        mem_din_r  <= mem_din_r;
        col_r      <= col_r;
        row_r      <= row_r;
      end
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_DONE) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_din   = mem_din_r;
  assign bus.col       = col_r;
  assign bus.row       = row_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_pixel_capture_writer.sv
// Randomized bench for pixel_capture_writer: a default 98x98 instance and a
// small 4x3 no-skip instance, both checked against a per-valid frame model.
module tb_pixel_capture_writer;

  localparam int DW   = 8;
  localparam int CHN  = 2;
  localparam int A_W  = 98;
  localparam int A_H  = 98;
  localparam int A_S  = 1;
  localparam int A_AW = 14;
  localparam int B_W  = 4;
  localparam int B_H  = 3;
  localparam int B_S  = 0;
  localparam int B_AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  // Model state per instance: 0 idle, 1 in frame, 2 finishing cycle.
  int phase[2], kv[2], msel[2], fc[2], geo_w[2], geo_h[2], geo_s[2], seen[2];
  int exp_we[2], exp_addr[2], exp_din[2], exp_col[2], exp_row[2], exp_busy[2], exp_done[2];
  int fin;
  int did;

  always #5 clk = ~clk;

  pixel_capture_writer_if #(.DATA_W(DW), .IMG_W(A_W), .IMG_H(A_H), .CH(CHN), .ADDR_W(A_AW)) if_a ();
  pixel_capture_writer_if #(.DATA_W(DW), .IMG_W(B_W), .IMG_H(B_H), .CH(CHN), .ADDR_W(B_AW)) if_b ();

  pixel_capture_writer #(.DATA_W(DW), .IMG_W(A_W), .IMG_H(A_H), .SKIP(A_S), .CH(CHN), .ADDR_W(A_AW))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pixel_capture_writer #(.DATA_W(DW), .IMG_W(B_W), .IMG_H(B_H), .SKIP(B_S), .CH(CHN), .ADDR_W(B_AW))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  // Predict the outputs after the coming edge from the inputs presented to it.
  task automatic model_step(input int d, input logic st, input int sel, input logic v, input int data);
    int p;
    exp_we[d] = 0;
    case (phase[d])
      2: phase[d] = 0;
      1: begin
        if (v) begin
          if (kv[d] >= geo_s[d]) begin
            p           = kv[d] - geo_s[d];
            exp_we[d]   = 1;
            exp_addr[d] = p;
            exp_col[d]  = p % geo_w[d];
            exp_row[d]  = p / geo_w[d];
            exp_din[d]  = (data >> (DW * msel[d])) & 255;
            if (p == geo_w[d] * geo_h[d] - 1) begin
              phase[d] = 2;
              fc[d]    = (fc[d] + 1) % 65536;
            end
          end
          kv[d]++;
        end
      end
      default: begin
        if (st) begin
          phase[d] = 1;
          kv[d]    = 0;
          msel[d]  = sel;
        end
      end
    endcase
    exp_busy[d] = (phase[d] != 0) ? 1 : 0;
    exp_done[d] = (phase[d] == 2) ? 1 : 0;
  endtask

  task automatic check_outs(input int d, input string pfx, input logic we, input logic [31:0] addr,
                            input logic [31:0] din, input logic [31:0] col, input logic [31:0] row,
                            input logic busy, input logic done, input logic [31:0] fcnt);
    check_val({pfx, "_we"}, {31'd0, we}, exp_we[d]);
    check_val({pfx, "_busy"}, {31'd0, busy}, exp_busy[d]);
    check_val({pfx, "_done"}, {31'd0, done}, exp_done[d]);
    check_val({pfx, "_fcnt"}, fcnt, fc[d]);
    if (exp_we[d] != 0) begin
      check_val({pfx, "_addr"}, addr, exp_addr[d]);
      check_val({pfx, "_din"}, din, exp_din[d]);
      check_val({pfx, "_col"}, col, exp_col[d]);
      check_val({pfx, "_row"}, row, exp_row[d]);
    end
    if (we) seen[d]++;
  endtask

  task automatic step();
    if_a.in_data = 16'($urandom);
    if_b.in_data = 16'($urandom);
    model_step(0, if_a.start, int'(if_a.ch_sel), if_a.in_valid, int'(if_a.in_data));
    model_step(1, if_b.start, int'(if_b.ch_sel), if_b.in_valid, int'(if_b.in_data));
    @(posedge clk);
    #1;
    check_outs(0, "a", if_a.mem_we, 32'(if_a.mem_addr), 32'(if_a.mem_din), 32'(if_a.col),
               32'(if_a.row), if_a.busy, if_a.done, 32'(if_a.frame_cnt));
    check_outs(1, "b", if_b.mem_we, 32'(if_b.mem_addr), 32'(if_b.mem_din), 32'(if_b.col),
               32'(if_b.row), if_b.busy, if_b.done, 32'(if_b.frame_cnt));
  endtask

  initial begin
    geo_w[0] = A_W; geo_h[0] = A_H; geo_s[0] = A_S;
    geo_w[1] = B_W; geo_h[1] = B_H; geo_s[1] = B_S;
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0; kv[d] = 0; msel[d] = 0; fc[d] = 0; seen[d] = 0;
    end
    if_a.start = 1'b0; if_a.ch_sel = 1'b0; if_a.in_valid = 1'b0; if_a.in_data = 16'd0;
    if_b.start = 1'b0; if_b.ch_sel = 1'b0; if_b.in_valid = 1'b0; if_b.in_data = 16'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_a_we",   {31'd0, if_a.mem_we}, 32'd0);
    check_val("rst_a_addr", 32'(if_a.mem_addr), 32'd0);
    check_val("rst_a_din",  32'(if_a.mem_din), 32'd0);
    check_val("rst_a_col",  32'(if_a.col), 32'd0);
    check_val("rst_a_row",  32'(if_a.row), 32'd0);
    check_val("rst_a_busy", {31'd0, if_a.busy}, 32'd0);
    check_val("rst_a_done", {31'd0, if_a.done}, 32'd0);
    check_val("rst_a_fcnt", 32'(if_a.frame_cnt), 32'd0);
    check_val("rst_b_we",   {31'd0, if_b.mem_we}, 32'd0);
    check_val("rst_b_busy", {31'd0, if_b.busy}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Frame aborted by reset after pixel 3000
    if_a.start = 1'b1; if_a.ch_sel = 1'($urandom_range(0, 1)); seen[0] = 0;
    step();
    if_a.start = 1'b0;
    for (int c = 0; c < 8000 && seen[0] < 3001; c++) begin
      if_a.in_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    if_a.in_valid = 1'b0;
    check_val("abort_reach", 32'(seen[0]), 32'd3001);
    check_val("abort_addr_before", 32'(if_a.mem_addr), 32'd3000);
    check_val("abort_we_before", {31'd0, if_a.mem_we}, 32'd1);
    rst = 1'b0;
    #2;
    check_val("abort_we", {31'd0, if_a.mem_we}, 32'd0);
    check_val("abort_busy", {31'd0, if_a.busy}, 32'd0);
    check_val("abort_fcnt", 32'(if_a.frame_cnt), 32'd0);
    check_val("abort_addr", 32'(if_a.mem_addr), 32'd0);
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0; fc[d] = 0;
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Valids while idle are ignored
    if_a.in_valid = 1'b1;
    repeat (20) step();
    if_a.in_valid = 1'b0;
    check_val("idle_no_write", 32'(seen[0]), 32'd3001);

    // Full frame, channel 0, back-to-back valids, then extra valids
    if_a.start = 1'b1; if_a.ch_sel = 1'b0; seen[0] = 0;
    step();
    if_a.start = 1'b0;
    if_a.in_valid = 1'b1;
    repeat (A_W * A_H + A_S) step();
    repeat (5) step();
    if_a.in_valid = 1'b0;
    step();
    check_val("f1_writes", 32'(seen[0]), 32'd9604);
    check_val("f1_last_addr", 32'(if_a.mem_addr), 32'd9603);
    check_val("f1_last_col", 32'(if_a.col), 32'd97);
    check_val("f1_last_row", 32'(if_a.row), 32'd97);
    check_val("f1_fcnt", 32'(if_a.frame_cnt), 32'd1);
    check_val("f1_idle", {31'd0, if_a.busy}, 32'd0);

    // Channel 1, valid every other cycle, ignored start at pixel 500, ch_sel noise
    if_a.start = 1'b1; if_a.ch_sel = 1'b1; seen[0] = 0;
    step();
    if_a.start = 1'b0;
    fin = 0; did = 0;
    for (int c = 0; c < 30000 && fin == 0; c++) begin
      if_a.in_valid = ((c % 2) == 1);
      if_a.ch_sel   = 1'($urandom_range(0, 1));
      if_a.start    = (seen[0] == 500 && did == 0);
      if (if_a.start) did = 1;
      step();
      if (if_a.done) fin = 1;
    end
    if_a.start = 1'b0; if_a.in_valid = 1'b0;
    step();
    check_val("f2_done_seen", 32'(fin), 32'd1);
    check_val("f2_writes", 32'(seen[0]), 32'd9604);
    check_val("f2_fcnt", 32'(if_a.frame_cnt), 32'd2);

    // Small no-skip instance, several frames with random gaps and start noise
    for (int f = 0; f < 6; f++) begin
      if_b.start = 1'b1; if_b.ch_sel = 1'($urandom_range(0, 1)); seen[1] = 0;
      step();
      if_b.start = 1'b0;
      fin = 0;
      for (int c = 0; c < 200 && fin == 0; c++) begin
        if_b.in_valid = (f == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if_b.ch_sel   = 1'($urandom_range(0, 1));
        if_b.start    = ($urandom_range(0, 6) == 0);
        step();
        if (if_b.done) fin = 1;
      end
      if_b.start = 1'b0; if_b.in_valid = 1'($urandom_range(0, 1));
      step();
      if_b.in_valid = 1'b0;
      check_val("b_done_seen", 32'(fin), 32'd1);
      check_val("b_writes", 32'(seen[1]), 32'd12);
      check_val("b_last_addr", 32'(if_b.mem_addr), 32'd11);
      check_val("b_last_col", 32'(if_b.col), 32'd3);
      check_val("b_last_row", 32'(if_b.row), 32'd2);
      check_val("b_fcnt", 32'(if_b.frame_cnt), 32'(f + 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_capture_writer.md
PIXEL_CAPTURE_WRITER -- requirements
Module: pixel_capture_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 98, output frame width in pixels.
REQ-003 SHALL have parameter IMG_H, default 98, output frame height in pixels.
REQ-004 SHALL have parameter SKIP, default 1, leading valid samples discarded per frame (0 allowed).
REQ-005 SHALL have parameter CH, default 2, number of input channels (0 = sobel, 1 = median, ...).
REQ-006 SHALL have parameter ADDR_W, default 14, memory address width; requires 2^ADDR_W >= IMG_W*IMG_H.
REQ-007 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, single-cycle request to capture one frame.
REQ-010 SHALL have port ch_sel, input, $clog2(CH) (min 1), channel selected for the frame.
REQ-011 SHALL have port in_valid, input, 1, pixel strobe (mem_write_en of the filter pipeline).
REQ-012 SHALL have port in_data, input, CH*DATA_W, channel c in bits [c*DATA_W +: DATA_W].
REQ-013 SHALL have port mem_we, output, 1, write enable to output image RAM.
REQ-014 SHALL have port mem_addr, output, ADDR_W, write address.
REQ-015 SHALL have port mem_din, output, DATA_W, write data.
REQ-016 SHALL have ports col, row, outputs, $clog2(IMG_W) / $clog2(IMG_H), position of current write.
REQ-017 SHALL have ports busy (1), done (1), frame_cnt (16), outputs.

Function
REQ-018 SHALL implement FSM IDLE -> SKIP -> CAPTURE -> DONE -> IDLE.
REQ-019 IDLE: start=1 SHALL latch ch_sel, clear counters, go to SKIP (or CAPTURE if SKIP==0).
REQ-020 start SHALL be ignored in any state other than IDLE; ch_sel changes mid-frame SHALL be ignored.
REQ-021 SKIP: each in_valid SHALL increment skip counter with no write; on SKIP-th sample go to CAPTURE.
REQ-022 CAPTURE: each in_valid SHALL produce, one cycle later, mem_we=1, mem_din = selected channel, mem_addr = pixel index.
REQ-023 Latency SHALL be exactly 1 clock from in_valid to mem_we; mem_we SHALL be 0 in all other cycles.
REQ-024 in_valid=0 cycles SHALL stall counters (gaps allowed, back-to-back valids every cycle supported).
REQ-025 mem_addr SHALL start at 0 and increment by 1 per write; col wraps IMG_W-1 -> 0 with row+1.
REQ-026 After write IMG_W*IMG_H-1 (row=IMG_H-1, col=IMG_W-1) FSM SHALL go to DONE; further in_valid ignored.
REQ-027 DONE SHALL last one cycle: done=1 pulse, frame_cnt+1 (wraps 0xFFFF -> 0), then IDLE.
REQ-028 busy SHALL be 1 in SKIP, CAPTURE, DONE; 0 in IDLE.
REQ-029 in_valid in IDLE SHALL be ignored.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, mem_we=0, mem_addr=0, mem_din=0, col=0, row=0, busy=0, done=0, frame_cnt=0.
REQ-031 rst asserted mid-frame SHALL abort with no further writes; next frame requires a new start.

Structure
REQ-032 FSM state encoding and default geometry constants (IMG_W, IMG_H, SKIP) SHALL live in shared package img_pkg.
REQ-033 One sub-module, xy_counter (col/row/linear address with wrap and last flag), SHALL be used.
REQ-034 Channel mux SHALL be combinational on latched ch_sel; all outputs registered.

Verification
REQ-035 Defaults, start, ch_sel=0, 9605 consecutive valids -> first skipped, 9604 writes addr 0..9603 = sobel data, done pulse, frame_cnt=1.
REQ-036 ch_sel=1, in_valid every other cycle -> mem_din equals median channel, 1-cycle latency, addr increments only on valid.
REQ-037 Last pixel -> row=97, col=97, mem_addr=9603; extra valids after -> no mem_we.
REQ-038 start while busy at pixel 500 -> ignored, addresses continue 501...
REQ-039 rst low at pixel 3000 -> mem_we drops immediately, busy=0, frame_cnt unchanged; new start writes from addr 0.
REQ-040 SKIP=0, IMG_W=4, IMG_H=3 -> 12 writes, col wraps 3->0 at addr 4 and 8, done after addr 11.
